alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
// - Multi-cycle wide-ALU controller. Drives one ALU4Bit slice (the 4-bit ALU with CLA) over
//   NIBBLES clock cycles, LSB nibble first, so the datapath gets a 4*NIBBLES-bit ALU from one slice.
// - Owns the slice's control side: issues op/cin/less, consumes result/cout/set, chains carry
//   between nibbles, applies SLT fix-up, builds the wide result and zero flag.
// PARAMETERS
// - NIBBLES   4   number of 4-bit slices processed; operand width W = 4*NIBBLES
// PORTS
// - clk      in   1     single clock, rising edge
// - rst      in   1     reset, asynchronous, active-high
// - start    in   1     request; sampled only in IDLE
// - a        in   W     operand A, latched on accepted start
// - b        in   W     operand B, latched on accepted start
// - op       in   3     010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT; latched on accepted start
// - busy     out  1     high from the cycle after accept until the cycle done pulses (inclusive)
// - done     out  1     one-cycle pulse; result/zero/cout valid and held until next accept
// - result   out  W     wide result
// - zero     out  1     1 iff result == 0 (full W bits, not the last slice's zero)
// - cout     out  1     carry out of the top nibble (slice c4); 0 for SLT and illegal ops
// BEHAVIOUR
// - Reset (any cycle, incl. mid-run): state IDLE, nibble counter 0, carry reg 0, busy 0, done 0,
//   result 0, zero 1, cout 0. Async assert; all regs clear without a clock edge.
// - States: IDLE -> RUN -> [FIX] -> DONE -> IDLE.
//   IDLE: start=1 and legal op -> latch a,b,op; counter=0; carry reg=op[2]; go RUN.
//         start=1 and illegal op (011,100,101) -> go DONE directly. result=0, zero=1, cout=0.
//   RUN:  drive slice with a[4k+3:4k], b[4k+3:4k], op, cin=carry reg, less=0 (k=counter).
//         Each cycle: write slice result into result[4k+3:4k], carry reg <= slice cout, k++.
//         k==NIBBLES-1: capture slice cout as cout and slice set as slt_bit.
//         Next state is FIX if op==SLT, else DONE.
//   FIX:  result <= {W-1 zeros, slt_bit}; cout <= 0. Go DONE.
//   DONE: done=1 for exactly this cycle; zero = (result==0). Go IDLE.
// - Latency: accept at edge T. RUN occupies T+1..T+NIBBLES. done is high in cycle T+NIBBLES+1
//   (ADD/SUB/AND/OR) or T+NIBBLES+2 (SLT). An illegal op gives done in cycle T+1.
// - start while not IDLE is ignored (not queued). start in the same cycle as done is also
//   ignored; the earliest back-to-back accept is the cycle after done.
// - Arithmetic: SUB/SLT set nibble-0 cin=1 (op[2]); the slice applies b-invert. Carry chains
//   only through the registered carry, so no combinational path runs from slice cout to
//   slice cin.
// - SLT uses the raw MSB sum bit (slice set) with no overflow correction. This matches the slice.
// - result bits of nibbles not yet written hold the previous value until overwritten. Consumers
//   sample only on done.
// - Outputs are registered, except done/busy, which decode from the state register.
// STRUCTURE
// - Shared header alu_defs.vh: op-code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT),
//   reused by the decoder and this block.
// - State encoding and counter width (clog2 NIBBLES) are local to this module.
// - One sub-module: a single ALU4Bit instance. Its g/p/zero outputs are left unconnected.
// TESTING
// - ADD 16'h00FF + 16'h0001 -> result 16'h0100, cout 0, zero 0; done 5 cycles after accept.
// - SUB 16'h1234 - 16'h1234 -> result 0, zero 1, cout 1.
//   SUB 16'h0000 - 16'h0001 -> 16'hFFFF, cout 0.
// - SLT a=16'h0003, b=16'h0005 -> result 16'h0001, done 6 cycles after accept.
//   SLT a=5, b=3 -> 16'h0000, zero 1.
// - AND 16'hF0F0 & 16'h3C3C -> 16'h3030.
//   OR of the same operands -> 16'hFCFC.
//   Illegal op 3'b100 -> done next cycle, result 0, zero 1.
// - Raise start during RUN with new operands -> ignored; the original result completes intact.
// - Assert rst in the 2nd RUN cycle -> busy/done/result drop to reset values immediately.
//   A new start after release completes normally.

Source files
------------

// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial wide ALU: op-code encodings and legality check.
// No ports; imported by the sequencer and its testbench.
// Op encoding is {b_invert, func[1:0]}, and the 4-bit slice decodes it directly.
package alu_nibble_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  // Codes 011, 100 and 101 have no defined wide meaning and are rejected up front.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between a datapath master and the wide-ALU sequencer.
// master: drives start/a/b/op and observes busy/done/result/zero/cout.
// slave : the sequencer. There is no backpressure; start is honoured only while idle.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;

  modport master (output start, a, b, op, input busy, done, result, zero, cout);
  modport slave  (input start, a, b, op, output busy, done, result, zero, cout);
endinterface

// File: rtl/alu_nibble_sequencer_alu4bit.sv
// 4-bit ALU slice with carry-lookahead: AND/OR/ADD/SLT, where op[2] inverts b.
// Combinational (zero latency). Ports: a,b,op,cin,less in; result,cout,set,g,p,zero out.
// set is the raw sum MSB, which feeds a set-less-than decision higher up.
module alu_nibble_sequencer_alu4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  input  logic       cin,
  input  logic       less,
  output logic [3:0] result,
  output logic       cout,
  output logic       set,
  output logic       g,
  output logic       p,
  output logic       zero
);
  logic [3:0] bb, gi, pi, sum;
  logic [3:0] c;

  always_comb begin
    bb   = op[2] ? ~b : b;
    gi   = a & bb;
    pi   = a ^ bb;
    c[0] = cin;
    c[1] = gi[0] | (pi[0] & cin);
    c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
    g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    p    = &pi;
    cout = g | (p & cin);
    sum  = pi ^ c;
    set  = sum[3];
    unique case (op[1:0])
      2'b00:   result = a & bb;
      2'b01:   result = a | bb;
      2'b10:   result = sum;
      default: result = {3'b000, less};
    endcase
    zero = (result == 4'h0);
  end
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Wide ALU built by running one 4-bit slice over NIBBLES cycles, LSB nibble first.
// Latency: done NIBBLES+1 cycles after accept (SLT +1, illegal op 1). Ports: clk, rst, bus(slave).
// No backpressure: start is sampled only in IDLE; requests while busy or during done are dropped.
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             slt_q, slt_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;

  logic [3:0] sl_a, sl_b, sl_result;
  logic       sl_cout, sl_set;

  always_comb begin
    sl_a = a_q[int'(cnt_q) * 4 +: 4];
    sl_b = b_q[int'(cnt_q) * 4 +: 4];
  end

  // Carry reaches the next nibble only through carry_q, so slice cout never loops to cin.
  alu_nibble_sequencer_alu4bit u_slice (
    .a      (sl_a),
    .b      (sl_b),
    .op     (op_q),
    .cin    (carry_q),
    .less   (1'b0),
    .result (sl_result),
    .cout   (sl_cout),
    .set    (sl_set),
    .g      (),
    .p      (),
    .zero   ()
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    slt_d    = slt_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_legal_op(bus.op)) begin
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = bus.op;
            cnt_d   = '0;
            carry_d = bus.op[2];  // SUB/SLT: +1 completes the two's complement of b
            state_d = ST_RUN;
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            cout_d   = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        result_d[int'(cnt_q) * 4 +: 4] = sl_result;
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = sl_cout;
          slt_d   = sl_set;
          zero_d  = (result_d == '0);
          state_d = (op_q == OP_SLT) ? ST_FIX : ST_DONE;
        end
      end
      ST_FIX: begin
        // Raw sign of a-b, no overflow correction, matching the slice's own SLT.
        result_d = {{(W-1){1'b0}}, slt_q};
        cout_d   = 1'b0;
        zero_d   = ~slt_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      slt_q    <= 1'b0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      slt_q    <= slt_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for the 16-bit (4-nibble) configuration of the wide-ALU sequencer.
// Drives requests through the interface and checks latency, result, zero, cout and busy/done.
// Expected values are hand-computed constants.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge following done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] ia,
                        input logic [15:0] ib, input logic [15:0] er, input logic ez,
                        input logic ec, input int elat);
    int n;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 16'hDEAD;
    bus.b     = 16'hBEEF;
    bus.op    = OP_ADD;
    n = 1;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_busy_at_done"}, bus.busy, 1);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_zero"}, bus.zero, ez);
    check({tag, "_cout"}, bus.cout, ec);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_held"}, bus.result, er);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_cout", bus.cout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add",     OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 5);
    run_op("sub_eq",  OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 5);
    run_op("sub_neg", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 5);
    run_op("slt_lt",  OP_SLT, 16'h0003, 16'h0005, 16'h0001, 1'b0, 1'b0, 6);
    run_op("slt_ge",  OP_SLT, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0, 6);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 5);
    run_op("add_msb", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 5);

    // AND/OR: the adder carry still drives cout, so only result/zero are compared here.
    bus.start = 1'b1; bus.op = OP_AND; bus.a = 16'hF0F0; bus.b = 16'h3C3C;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
    check("and_latency", n, 5);
    check("and_result", bus.result, 16'h3030);
    check("and_zero", bus.zero, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_OR;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
    check("or_latency", n, 5);
    check("or_result", bus.result, 16'hFCFC);
    @(posedge clk); #1;

    run_op("illegal", 3'b100, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1);

    // New start during RUN and during the done cycle must be dropped.
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h00FF; bus.b = 16'h0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.op = OP_SUB; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    n = 2;
    while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
    check("ignore_latency", n, 5);
    check("ignore_result", bus.result, 16'h0100);
    check("ignore_zero", bus.zero, 0);
    @(posedge clk); #1;
    check("ignore_done_cycle_start", bus.busy, 0);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // Reset in the second RUN cycle clears everything without waiting for a clock.
    bus.start = 1'b1; bus.op = OP_SUB; bus.a = 16'h1234; bus.b = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("midrst_running", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_zero", bus.zero, 1);
    check("midrst_cout", bus.cout, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_stays_idle", bus.busy, 0);
    run_op("post_rst", OP_SUB, 16'h1234, 16'h1111, 16'h0123, 1'b0, 1'b1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
